// File: rtl/wb_pkg.sv
// Shared constants and helpers for the writeback commit stage.
package wb_pkg;

  localparam int RegAddrW = 5;
  localparam int NumRegs  = 32;
  localparam int PendW    = 2;

  localparam logic [PendW-1:0] PendMax = '1;

  // Next value of one pending-write counter. A simultaneous issue and
  // commit cancel out; a decrement of zero saturates at zero (the caller
  // flags that case separately).
  function automatic logic [PendW-1:0] pend_next(
    input logic [PendW-1:0] cur,
    input logic             inc,
    input logic             dec
  );
    logic [PendW-1:0] nxt;
    nxt = cur;
    if (inc && !dec)
      nxt = cur + PendW'(1);
    else if (dec && !inc && cur != '0)
      nxt = cur - PendW'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO: flat entries, wrap-bit pointers, synchronous clear.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int Width = 37,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW   = $clog2(Depth);
  localparam int PtrW = AW + 1;

  logic [PtrW-1:0]  wptr, rptr;
  logic [Width-1:0] mem [Depth];
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; clear discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PtrW'(1);
      if (do_pop)  rptr <= rptr + PtrW'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: result FIFO, GPR write register, pending-write scoreboard.
module wb_commit
  import wb_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int Depth    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [4:0]          res_rdn,
  input  logic [WordSize-1:0] res_data,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rdn,
  output logic                issue_ready,
  input  logic [4:0]          rs1n,
  input  logic [4:0]          rs2n,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                wbe,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] rdd,
  output logic                sb_err
);

  typedef struct packed {
    logic [RegAddrW-1:0] rdn;
    logic [WordSize-1:0] data;
  } wb_entry_t;

  localparam int EntryW = $bits(wb_entry_t);

  wb_entry_t                         in_e, head_e;
  logic [EntryW-1:0]                 head_flat;
  logic                              full, empty, push, pop;
  logic [NumRegs-1:0][PendW-1:0]     cnt;
  logic [NumRegs-1:0]                inc_v, dec_v;
  logic                              uflow, iss;

  // ---------------- result FIFO ----------------
  assign res_ready = !full;
  assign in_e      = '{rdn: res_rdn, data: res_data};
  // x0 results complete the handshake but are dropped here.
  assign push      = res_valid && res_ready && (res_rdn != '0) && !flush;
  assign pop       = !empty && !flush;
  assign head_e    = wb_entry_t'(head_flat);

  wb_fifo #(.Width(EntryW), .Depth(Depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_e),
    .rdata (head_flat),
    .full  (full),
    .empty (empty)
  );

  // GPR write port: one-cycle pulse per popped entry, address/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbe <= 1'b0;
      rdn <= '0;
      rdd <= '0;
    end else begin
      wbe <= pop;
      if (pop) begin
        rdn <= head_e.rdn;
        rdd <= head_e.data;
      end
    end
  end

  // ---------------- scoreboard ----------------
  assign issue_ready = (issue_rdn == '0) || (cnt[issue_rdn] != PendMax);
  assign iss         = issue_valid && issue_ready && (issue_rdn != '0);
  assign rs1_busy    = (cnt[rs1n] != '0);
  assign rs2_busy    = (cnt[rs2n] != '0);

  // Per-register increment/decrement strobes and underflow detection.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    uflow = 1'b0;
    for (int i = 1; i < NumRegs; i++) begin
      inc_v[i] = iss && (issue_rdn == RegAddrW'(i));
      dec_v[i] = wbe && (rdn == RegAddrW'(i));
      if (dec_v[i] && !inc_v[i] && cnt[i] == '0) uflow = 1'b1;
    end
  end

  // Counter array; x0 is held at zero so it never reads busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NumRegs; i++)
        cnt[i] <= pend_next(cnt[i], inc_v[i], dec_v[i]);
    end
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb_err <= 1'b0;
    else if (uflow && !flush)
      sb_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: queue/array reference model plus
// directed literal checks and a randomized phase.
module tb_wb_commit;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, flush, res_valid, issue_valid;
  logic         res_ready, issue_ready, rs1_busy, rs2_busy, wbe, sb_err;
  logic [4:0]   res_rdn, issue_rdn, rs1n, rs2n, rdn;
  logic [W-1:0] res_data, rdd;

  wb_commit #(.WordSize(W), .Depth(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_rdn(res_rdn), .res_data(res_data),
    .issue_valid(issue_valid), .issue_rdn(issue_rdn), .issue_ready(issue_ready),
    .rs1n(rs1n), .rs2n(rs2n), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wbe(wbe), .rdn(rdn), .rdd(rdd), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] r; logic [W-1:0] d; } ent_t;
  ent_t       q[$];
  int         pend[32];
  logic       m_wbe, m_err;
  logic [4:0] m_rdn;
  logic [W-1:0] m_rdd;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    foreach (pend[i]) pend[i] = 0;
    m_wbe = 0; m_rdn = 0; m_rdd = 0; m_err = 0;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic compare();
    logic exp_ir;
    exp_ir = (issue_rdn == 0) || (pend[issue_rdn] < 3);
    chk("res_ready", res_ready, (q.size() < D));
    chk("issue_ready", issue_ready, exp_ir);
    chk("rs1_busy", rs1_busy, (rs1n != 0 && pend[rs1n] > 0));
    chk("rs2_busy", rs2_busy, (rs2n != 0 && pend[rs2n] > 0));
    chk("wbe", wbe, m_wbe);
    chk("rdn", rdn, m_rdn);
    chk("rdd", rdd, m_rdd);
    chk("sb_err", sb_err, m_err);
  endtask

  // One clock: inputs already driven after a negedge. Check, advance the
  // model with what the rules say happens at this edge, then move on.
  task automatic step();
    ent_t e;
    logic acc, ir, n_wbe, n_err;
    logic [4:0] n_rdn;
    logic [W-1:0] n_rdd;
    int   n_pend[32];
    int   ir_reg, cm_reg;
    #1;
    compare();
    acc   = res_valid && (q.size() < D);
    ir    = (issue_rdn == 0) || (pend[issue_rdn] < 3);
    n_pend = pend;
    n_err = m_err;
    n_rdn = m_rdn;
    n_rdd = m_rdd;
    n_wbe = 0;
    if (flush) begin
      foreach (n_pend[i]) n_pend[i] = 0;
    end else begin
      ir_reg = (issue_valid && ir && issue_rdn != 0) ? int'(issue_rdn) : 0;
      cm_reg = m_wbe ? int'(m_rdn) : 0;
      if (ir_reg != cm_reg) begin
        if (ir_reg != 0) n_pend[ir_reg]++;
        if (cm_reg != 0) begin
          if (n_pend[cm_reg] == 0) n_err = 1;
          else n_pend[cm_reg]--;
        end
      end
    end
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        n_wbe = 1; n_rdn = e.r; n_rdd = e.d;
      end
      if (acc && res_rdn != 0) begin
        e.r = res_rdn; e.d = res_data;
        q.push_back(e);
      end
    end
    pend = n_pend; m_err = n_err;
    m_wbe = n_wbe; m_rdn = n_rdn; m_rdd = n_rdd;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; res_valid = 0; res_rdn = 0; res_data = 0;
    issue_valid = 0; issue_rdn = 0;
  endtask

  // Asynchronous reset between edges; outputs must drop at once.
  task automatic do_reset();
    rst = 1;
    idle_inputs();
    #1;
    chk("rst_wbe", wbe, 0);
    chk("rst_rdn", rdn, 0);
    chk("rst_rdd", rdd, 0);
    chk("rst_sb_err", sb_err, 0);
    chk("rst_res_ready", res_ready, 1);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_rs1_busy", rs1_busy, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic send(input logic [4:0] r, input logic [W-1:0] d);
    res_valid = 1; res_rdn = r; res_data = d;
    step();
    res_valid = 0;
  endtask

  initial begin
    int pulses, nexp;
    rst = 1; rs1n = 0; rs2n = 0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    do_reset();

    // Single result: accept at edge 1, write visible after edge 2 only.
    res_valid = 1; res_rdn = 5; res_data = 32'hDEADBEEF;
    #1 chk("single_ready", res_ready, 1);
    step();
    res_valid = 0;
    chk("single_wbe_c1", wbe, 0);
    step();
    chk("single_wbe_c2", wbe, 1);
    chk("single_rdn", rdn, 5);
    chk("single_rdd", rdd, 32'hDEADBEEF);
    step();
    chk("single_wbe_c3", wbe, 0);
    chk("single_hold", rdd, 32'hDEADBEEF);

    // Back-to-back stream of 8: all written once, in order.
    pulses = 0; nexp = 0;
    for (int i = 0; i < 10; i++) begin
      res_valid = (i < 8);
      res_rdn   = 5'((i % 7) + 1);
      res_data  = 32'(i * 32'h111);
      step();
      if (wbe) begin
        chk("stream_rdn", rdn, 5'((nexp % 7) + 1));
        chk("stream_rdd", rdd, 32'(nexp * 32'h111));
        nexp++; pulses++;
      end
    end
    chk("stream_count", pulses, 8);

    // x0 results and issues are invisible.
    issue_valid = 1; issue_rdn = 0; rs1n = 0;
    send(0, 32'h1234);
    issue_valid = 0;
    step();
    chk("x0_wbe", wbe, 0);
    chk("x0_busy", rs1_busy, 0);

    // Scoreboard saturation, commit release, busy timing.
    issue_valid = 1; issue_rdn = 7; rs1n = 7;
    step(); step(); step();
    issue_valid = 0;
    #1 chk("sb_full_ready", issue_ready, 0);
    send(7, 32'h70);
    step();
    chk("sb_wbe", wbe, 1);
    chk("sb_still_full", issue_ready, 0);
    step();
    chk("sb_released", issue_ready, 1);
    chk("sb_busy2", rs1_busy, 1);
    send(7, 32'h71);
    step();                                   // wbe=1 for rd7, count 2
    issue_valid = 1; issue_rdn = 7;
    step();                                   // issue + commit cancel
    issue_valid = 0;
    send(7, 32'h72); step(); step();          // count 1
    chk("sb_busy1", rs1_busy, 1);
    send(7, 32'h73); step();
    chk("sb_last_wbe", wbe, 1);
    chk("sb_busy_in_wbe", rs1_busy, 1);
    step();
    chk("sb_busy_clear", rs1_busy, 0);

    // Flush with queued entry, pending rd9 and a concurrent result.
    issue_valid = 1; issue_rdn = 9; rs1n = 9;
    step();
    issue_valid = 0;
    send(3, 32'h33);
    res_valid = 1; res_rdn = 4; res_data = 32'h44; flush = 1;
    step();
    flush = 0; res_valid = 0;
    chk("flush_wbe", wbe, 0);
    chk("flush_busy9", rs1_busy, 0);
    step();
    chk("flush_no_accept", wbe, 0);

    // Commit without issue -> sticky error surviving flush.
    send(12, 32'hC);
    step(); step();
    chk("uflow_err", sb_err, 1);
    flush = 1; step(); flush = 0;
    chk("err_after_flush", sb_err, 1);

    // Async reset while a write is on the port.
    issue_valid = 1; issue_rdn = 6; rs1n = 6;
    step();
    issue_valid = 0;
    send(6, 32'h66);
    step();
    chk("pre_rst_wbe", wbe, 1);
    do_reset();
    step();
    chk("post_rst_wbe", wbe, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      flush       = ($urandom_range(0, 99) < 3);
      res_valid   = ($urandom_range(0, 1) == 1);
      res_rdn     = 5'($urandom_range(0, 7));
      res_data    = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rdn   = 5'($urandom_range(0, 7));
      rs1n        = 5'($urandom_range(0, 31));
      rs2n        = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
